// File: rtl/vga_fb_painter_if.sv
// Command and frame-RAM port bundle for vga_fb_painter.
// The master side issues fill commands and returns read data; the slave side is the painter.
interface vga_fb_painter_if #(
    parameter int COLOR_W = 3
) ();
    logic               iCmdValid;
    logic               oCmdReady;
    logic [10:0]        iX0;
    logic [10:0]        iX1;
    logic [9:0]         iY0;
    logic [9:0]         iY1;
    logic [COLOR_W-1:0] iColor;
    logic               oWrEn;
    logic [10:0]        oWrCol;
    logic [9:0]         oWrRow;
    logic [COLOR_W-1:0] oWrData;
    logic [10:0]        oRdCol;
    logic [9:0]         oRdRow;
    logic [COLOR_W-1:0] iRdData;

    modport master (
        output iCmdValid, iX0, iX1, iY0, iY1, iColor, iRdData,
        input  oCmdReady, oWrEn, oWrCol, oWrRow, oWrData, oRdCol, oRdRow
    );

    modport slave (
        input  iCmdValid, iX0, iX1, iY0, iY1, iColor, iRdData,
        output oCmdReady, oWrEn, oWrCol, oWrRow, oWrData, oRdCol, oRdRow
    );
endinterface

// File: rtl/vga_fb_painter.sv
// VGA raster scanner from a frame RAM plus a rectangle-fill write engine.
// Optional FB_CLEAR_ON_RESET_EN: after reset the engine writes colour 0 over the whole active frame.
module vga_fb_painter #(
    parameter int COLOR_W  = 3,
    parameter int PIX_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic               Clock,
    input  logic               Reset,
    vga_fb_painter_if.slave    bus,
    output logic               VGA_HSYNC,
    output logic               VGA_VSYNC,
    output logic [COLOR_W-1:0] VGA_RGB
);
    localparam logic [2:0]  DIV_LAST  = 3'(PIX_DIV - 1);
    localparam logic [10:0] H_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_ACT_END = 10'(V_ACTIVE - 1);
    localparam logic [10:0] HS_FIRST  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VS_FIRST  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FILL = 2'd1, ST_CLEAR = 2'd2} state_t;

    logic [2:0]         div_cnt_r;
    logic               pix_en_s;
    logic [10:0]        col_r;
    logic [9:0]         row_r;
    logic               active_s;
    logic               hsync_s;
    logic               vsync_s;
    logic               hsync_r;
    logic               vsync_r;
    logic [COLOR_W-1:0] rgb_r;

    state_t             state_r, state_nxt_s;
    logic               wr_en_r, wr_en_nxt_s;
    logic [10:0]        wr_col_r, wr_col_nxt_s;
    logic [9:0]         wr_row_r, wr_row_nxt_s;
    logic [COLOR_W-1:0] wr_data_r, wr_data_nxt_s;
    logic [10:0]        xmin_r, xmin_nxt_s, xmax_r, xmax_nxt_s;
    logic [9:0]         ymax_r, ymax_nxt_s;
    logic [10:0]        xlo_s, xhi_s;
    logic [9:0]         ylo_s, yhi_s;
    logic               cmd_empty_s;

    assign pix_en_s = (div_cnt_r == DIV_LAST);
    assign active_s = (col_r <= H_ACT_END) && (row_r <= V_ACT_END);
    assign hsync_s  = !((col_r >= HS_FIRST) && (col_r <= HS_LAST));
    assign vsync_s  = !((row_r >= VS_FIRST) && (row_r <= VS_LAST));

    // Pixel-enable divider
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            div_cnt_r <= 3'd0;
        end else if (pix_en_s) begin
            div_cnt_r <= 3'd0;
        end else begin
            div_cnt_r <= div_cnt_r + 3'd1;
        end
    end

    // Raster counters and the one-pixel-delayed video outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            col_r   <= 11'd0;
            row_r   <= 10'd0;
            hsync_r <= 1'b1;
            vsync_r <= 1'b1;
            rgb_r   <= '0;
        end else if (pix_en_s) begin
            hsync_r <= hsync_s;
            vsync_r <= vsync_s;
            rgb_r   <= active_s ? bus.iRdData : '0;
            if (col_r == H_LAST) begin
                col_r <= 11'd0;
                row_r <= (row_r == V_LAST) ? 10'd0 : row_r + 10'd1;
            end else begin
                col_r <= col_r + 11'd1;
            end
        end
    end

    // Sort the corners and clip the far edges to the visible frame
    always_comb begin
        xlo_s = (bus.iX0 <= bus.iX1) ? bus.iX0 : bus.iX1;
        xhi_s = (bus.iX0 <= bus.iX1) ? bus.iX1 : bus.iX0;
        ylo_s = (bus.iY0 <= bus.iY1) ? bus.iY0 : bus.iY1;
        yhi_s = (bus.iY0 <= bus.iY1) ? bus.iY1 : bus.iY0;
        if (xhi_s > H_ACT_END) begin
            xhi_s = H_ACT_END;
        end else begin
            xhi_s = xhi_s;
        end
        if (yhi_s > V_ACT_END) begin
            yhi_s = V_ACT_END;
        end else begin
            yhi_s = yhi_s;
        end
        cmd_empty_s = (xlo_s > H_ACT_END) || (ylo_s > V_ACT_END);
    end

    // Engine next state: write registers hold the pixel being written this cycle
    always_comb begin
        state_nxt_s   = state_r;
        wr_en_nxt_s   = wr_en_r;
        wr_col_nxt_s  = wr_col_r;
        wr_row_nxt_s  = wr_row_r;
        wr_data_nxt_s = wr_data_r;
        xmin_nxt_s    = xmin_r;
        xmax_nxt_s    = xmax_r;
        ymax_nxt_s    = ymax_r;
        case (state_r)
            ST_IDLE: begin
                wr_en_nxt_s = 1'b0;
                if (bus.iCmdValid && !cmd_empty_s) begin
                    state_nxt_s   = ST_FILL;
                    wr_en_nxt_s   = 1'b1;
                    wr_col_nxt_s  = xlo_s;
                    wr_row_nxt_s  = ylo_s;
                    wr_data_nxt_s = bus.iColor;
                    xmin_nxt_s    = xlo_s;
                    xmax_nxt_s    = xhi_s;
                    ymax_nxt_s    = yhi_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL, ST_CLEAR: begin
                if (!wr_en_r) begin
                    // Only reachable when CLEAR leaves reset: start a full-frame fill of 0
                    wr_en_nxt_s   = 1'b1;
                    wr_col_nxt_s  = 11'd0;
                    wr_row_nxt_s  = 10'd0;
                    wr_data_nxt_s = '0;
                    xmin_nxt_s    = 11'd0;
                    xmax_nxt_s    = H_ACT_END;
                    ymax_nxt_s    = V_ACT_END;
                end else if ((wr_col_r == xmax_r) && (wr_row_r == ymax_r)) begin
                    wr_en_nxt_s = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else if (wr_col_r == xmax_r) begin
                    wr_col_nxt_s = xmin_r;
                    wr_row_nxt_s = wr_row_r + 10'd1;
                end else begin
                    wr_col_nxt_s = wr_col_r + 11'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                wr_en_nxt_s = 1'b0;
            end
        endcase
    end

    // Engine state and write-port registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
`ifdef FB_CLEAR_ON_RESET_EN
            state_r   <= ST_CLEAR;
`else
            state_r   <= ST_IDLE;
`endif
            wr_en_r   <= 1'b0;
            wr_col_r  <= 11'd0;
            wr_row_r  <= 10'd0;
            wr_data_r <= '0;
            xmin_r    <= 11'd0;
            xmax_r    <= 11'd0;
            ymax_r    <= 10'd0;
        end else begin
            state_r   <= state_nxt_s;
            wr_en_r   <= wr_en_nxt_s;
            wr_col_r  <= wr_col_nxt_s;
            wr_row_r  <= wr_row_nxt_s;
            wr_data_r <= wr_data_nxt_s;
            xmin_r    <= xmin_nxt_s;
            xmax_r    <= xmax_nxt_s;
            ymax_r    <= ymax_nxt_s;
        end
    end

    assign bus.oCmdReady = (state_r == ST_IDLE);
    assign bus.oWrEn     = wr_en_r;
    assign bus.oWrCol    = wr_col_r;
    assign bus.oWrRow    = wr_row_r;
    assign bus.oWrData   = wr_data_r;
    assign bus.oRdCol    = col_r;
    assign bus.oRdRow    = row_r;
    assign VGA_HSYNC     = hsync_r;
    assign VGA_VSYNC     = vsync_r;
    assign VGA_RGB       = rgb_r;
endmodule

// File: tb/tb_vga_fb_painter.sv
// Scoreboard bench for vga_fb_painter: fill writes are predicted into a queue and
// popped as the write port fires; raster timing is checked by counting over whole periods.
module tb_vga_fb_painter;
    localparam int CW = 3;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    vga_fb_painter_if #(.COLOR_W(CW)) bus ();
    vga_fb_painter_if #(.COLOR_W(CW)) sbus ();
    logic          hs, vs, shs, svs;
    logic [CW-1:0] rgb, srgb;

    vga_fb_painter #(.COLOR_W(CW)) dut (
        .Clock(Clock), .Reset(Reset), .bus(bus.slave),
        .VGA_HSYNC(hs), .VGA_VSYNC(vs), .VGA_RGB(rgb)
    );

    // Tiny raster so a whole frame fits in a few hundred cycles
    vga_fb_painter #(
        .COLOR_W(CW), .PIX_DIV(3),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_small (
        .Clock(Clock), .Reset(Reset), .bus(sbus.slave),
        .VGA_HSYNC(shs), .VGA_VSYNC(svs), .VGA_RGB(srgb)
    );

    int          errs   = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          wr_seen = 0;
    logic [23:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    initial forever begin
        @(posedge Clock);
        cyc++;
    end

    // Write-port monitor: every write must match the next predicted pixel
    initial forever begin
        logic [23:0] e;
        @(negedge Clock);
        if (!Reset && bus.oWrEn) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_wr", {bus.oWrCol, bus.oWrRow, bus.oWrData}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_word", {8'd0, bus.oWrCol, bus.oWrRow, bus.oWrData}, {8'd0, e});
            end
        end
    end

    // Reference rectangle: sort corners, clip to 640x480, emit raster-order pixels
    task automatic push_rect(input int x0, input int y0, input int x1, input int y1,
                             input int color, output int n);
        int xa, xb, ya, yb;
        xa = (x0 < x1) ? x0 : x1;
        xb = (x0 < x1) ? x1 : x0;
        ya = (y0 < y1) ? y0 : y1;
        yb = (y0 < y1) ? y1 : y0;
        if (xb > 639) xb = 639;
        if (yb > 479) yb = 479;
        n = 0;
        if (xa <= 639 && ya <= 479) begin
            for (int y = ya; y <= yb; y++) begin
                for (int x = xa; x <= xb; x++) begin
                    exp_q.push_back({11'(x), 10'(y), 3'(color)});
                    n++;
                end
            end
        end
    endtask

    task automatic send_cmd(input string tag, input int x0, input int y0, input int x1,
                            input int y1, input int color, input bit poke);
        int n, c0, t, w0;
        push_rect(x0, y0, x1, y1, color, n);
        w0 = wr_seen;
        @(negedge Clock);
        check_eq({tag, "_ready_before"}, bus.oCmdReady, 1);
        bus.iCmdValid = 1'b1;
        bus.iX0 = 11'(x0); bus.iY0 = 10'(y0);
        bus.iX1 = 11'(x1); bus.iY1 = 10'(y1);
        bus.iColor = 3'(color);
        @(posedge Clock);
        #1;
        c0 = cyc;
        // Scramble the command inputs; the fill must keep its latched values
        bus.iX0 = 11'd100; bus.iY0 = 10'd100; bus.iX1 = 11'd200; bus.iY1 = 10'd200;
        bus.iColor = ~3'(color);
        if (poke) begin
            @(posedge Clock);
            @(posedge Clock);
            #1;
        end
        bus.iCmdValid = 1'b0;
        t = 0;
        @(negedge Clock);
        while (!bus.oCmdReady && t < 2000) begin
            @(negedge Clock);
            t++;
        end
        check_eq({tag, "_ready_lat"}, cyc - c0, n);
        check_eq({tag, "_wr_count"}, wr_seen - w0, n);
        repeat (4) @(negedge Clock);
        check_eq({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int hs_low, rgb_on, s_hs_low, s_vs_low, s_rgb_on, vs_low, blank_rgb, n;
        bus.iCmdValid = 1'b0;
        bus.iX0 = 11'd0; bus.iX1 = 11'd0; bus.iY0 = 10'd0; bus.iY1 = 10'd0;
        bus.iColor = 3'd0; bus.iRdData = 3'b111;
        sbus.iCmdValid = 1'b0;
        sbus.iX0 = 11'd0; sbus.iX1 = 11'd0; sbus.iY0 = 10'd0; sbus.iY1 = 10'd0;
        sbus.iColor = 3'd0; sbus.iRdData = 3'b111;

        repeat (3) @(negedge Clock);
        check_eq("rst_wren", bus.oWrEn, 0);
        check_eq("rst_wrcol", bus.oWrCol, 0);
        check_eq("rst_wrrow", bus.oWrRow, 0);
        check_eq("rst_wrdata", bus.oWrData, 0);
        check_eq("rst_hsync", hs, 1);
        check_eq("rst_vsync", vs, 1);
        check_eq("rst_rgb", rgb, 0);
        check_eq("rst_rdcol", bus.oRdCol, 0);
        check_eq("rst_rdrow", bus.oRdRow, 0);
        check_eq("rst_ready", bus.oCmdReady, 1);

        // One full line of the main raster and one full frame of the small one
        Reset = 1'b0;
        hs_low = 0; rgb_on = 0; vs_low = 0; blank_rgb = 0;
        s_hs_low = 0; s_vs_low = 0; s_rgb_on = 0;
        for (int i = 1; i <= 1600; i++) begin
            @(negedge Clock);
            if (i == 1) check_eq("pixen_edge1_col", bus.oRdCol, 0);
            if (i == 2) check_eq("pixen_edge2_col", bus.oRdCol, 1);
            if (!hs) hs_low++;
            if (!vs) vs_low++;
            if (rgb == 3'b111) rgb_on++;
            if (i > 1281 && rgb != 3'b000) blank_rgb++;
            if (i <= 360) begin
                if (!shs) s_hs_low++;
                if (!svs) s_vs_low++;
                if (srgb == 3'b111) s_rgb_on++;
            end
        end
        check_eq("line_hsync_low_clk", hs_low, 192);
        check_eq("line_vsync_low_clk", vs_low, 0);
        check_eq("line_rgb_active_clk", rgb_on, 1280);
        check_eq("line_rgb_blank", blank_rgb, 0);
        check_eq("small_hsync_low_clk", s_hs_low, 72);
        check_eq("small_vsync_low_clk", s_vs_low, 90);
        check_eq("small_rgb_active_clk", s_rgb_on, 96);

        send_cmd("rect_fwd", 10, 20, 12, 21, 5, 1'b1);
        send_cmd("rect_rev", 12, 21, 10, 20, 5, 1'b1);
        send_cmd("rect_clip", 638, 478, 700, 600, 3, 1'b1);
        send_cmd("rect_off", 700, 10, 800, 20, 6, 1'b0);
        send_cmd("pixel", 5, 5, 5, 5, 2, 1'b0);
        send_cmd("row_strip", 0, 0, 3, 0, 7, 1'b1);

        // Reset during the third write of a 3x2 fill
        push_rect(10, 20, 12, 21, 5, n);
        @(negedge Clock);
        bus.iCmdValid = 1'b1;
        bus.iX0 = 11'd10; bus.iY0 = 10'd20; bus.iX1 = 11'd12; bus.iY1 = 10'd21;
        bus.iColor = 3'b101;
        @(posedge Clock);
        #1;
        bus.iCmdValid = 1'b0;
        @(posedge Clock);
        @(posedge Clock);
        #1;
        check_eq("mid_wren_before", bus.oWrEn, 1);
        Reset = 1'b1;
        #1;
        check_eq("mid_wren", bus.oWrEn, 0);
        check_eq("mid_wrcol", bus.oWrCol, 0);
        check_eq("mid_wrrow", bus.oWrRow, 0);
        check_eq("mid_wrdata", bus.oWrData, 0);
        check_eq("mid_ready", bus.oCmdReady, 1);
        check_eq("mid_hsync", hs, 1);
        check_eq("mid_rgb", rgb, 0);
        check_eq("mid_rdcol", bus.oRdCol, 0);
        check_eq("mid_q_left", exp_q.size(), n - 2);
        exp_q.delete();
        repeat (4) @(negedge Clock);
        check_eq("mid_hold_wren", bus.oWrEn, 0);
        Reset = 1'b0;
        repeat (20) @(negedge Clock);
        check_eq("post_rst_ready", bus.oCmdReady, 1);
        check_eq("post_rst_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
